// File: rtl/uart_tx_feeder_if.sv
// Byte-queue and bit-path handshake signals of uart_tx_feeder.
interface uart_tx_feeder_if #(
    parameter int unsigned FIFO_AW = 4
);
    logic [7:0]       wr_data;
    logic             wr_en;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FIFO_AW:0] fifo_count;
    logic             overflow;
    logic             timeout_err;
    logic             err_clear;
    logic [7:0]       tx_data;
    logic             tx_enable;
    logic             tx_busy;
    logic             tx_idle;

    // System logic and the downstream bit-path.
    modport master (
        output wr_data, wr_en, err_clear, tx_busy,
        input  fifo_full, fifo_empty, fifo_count, overflow, timeout_err,
               tx_data, tx_enable, tx_idle
    );

    // The feeder itself.
    modport slave (
        input  wr_data, wr_en, err_clear, tx_busy,
        output fifo_full, fifo_empty, fifo_count, overflow, timeout_err,
               tx_data, tx_enable, tx_idle
    );
endinterface

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus launch sequencer feeding the UART transmit bit-path.
// Each byte is presented on tx_data with a tx_enable pulse, the controller
// waits for the bit-path busy cycle, then holds off for GAP_CYCLES clocks.
module uart_tx_feeder #(
    parameter int unsigned FIFO_AW     = 4,
    parameter int unsigned GAP_CYCLES  = 4,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic            uart_tx_clk,
    input  logic            reset_n,
    uart_tx_feeder_if.slave bus
);
    localparam int unsigned      DEPTH      = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_COUNT = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [7:0]       ACK_LAST   = 8'(ACK_TIMEOUT - 1);
    localparam logic [7:0]       GAP_LAST   = 8'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ASSERT,
        WAIT_DONE,
        GAP
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic [7:0]         timer;
    logic [7:0]         tx_data_q;
    logic               overflow_q;
    logic               timeout_q;
    logic               full;
    logic               empty;
    logic               push;
    logic               drop;
    logic               pop;
    logic               ack_expired;

    // Full/empty come from the registered count, so a write while full is
    // dropped even if a pop happens in the same cycle.
    assign full        = (count == FULL_COUNT);
    assign empty       = (count == '0);
    assign push        = bus.wr_en && !full;
    assign drop        = bus.wr_en && full;
    assign pop         = (state == LOAD);
    assign ack_expired = (state == ASSERT) && !bus.tx_busy && (timer == ACK_LAST);

    assign bus.fifo_full   = full;
    assign bus.fifo_empty  = empty;
    assign bus.fifo_count  = count;
    assign bus.overflow    = overflow_q;
    assign bus.timeout_err = timeout_q;
    assign bus.tx_data     = tx_data_q;

    // Byte storage; entries are only meaningful between the pointers, so no reset.
    always_ff @(posedge uart_tx_clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge uart_tx_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            if (push && !pop) begin
                count <= count + (FIFO_AW + 1)'(1);
            end else if (pop && !push) begin
                count <= count - (FIFO_AW + 1)'(1);
            end
        end
    end

    // Sticky error flags; a clear wins over a same-cycle set.
    always_ff @(posedge uart_tx_clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else if (bus.err_clear) begin
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            if (drop) begin
                overflow_q <= 1'b1;
            end
            if (ack_expired) begin
                timeout_q <= 1'b1;
            end
        end
    end

    // Launch byte register; changes only when a byte is popped.
    always_ff @(posedge uart_tx_clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_data_q <= '0;
        end else if (state == LOAD) begin
            tx_data_q <= mem[rd_ptr];
        end
    end

    // State register; the shared timer restarts from zero on every state change.
    always_ff @(posedge uart_tx_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                timer <= '0;
            end else begin
                timer <= timer + 8'd1;
            end
        end
    end

    // Next-state logic for the launch sequencer.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                state_next = ASSERT;
            end
            ASSERT: begin
                if (bus.tx_busy) begin
                    state_next = WAIT_DONE;
                end else if (timer == ACK_LAST) begin
                    state_next = GAP;
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_next = GAP;
                end
            end
            GAP: begin
                if (timer == GAP_LAST) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        bus.tx_enable = (state == ASSERT);
        bus.tx_idle   = (state == IDLE) && empty;
    end
endmodule

// File: tb/tb_uart_tx_feeder.sv
// Scoreboard bench for uart_tx_feeder: stimulus pushes expected bytes,
// a monitor pops and compares on every tx_enable rising edge, and a simple
// bit-path model answers launches with a busy frame.
module tb_uart_tx_feeder;
    localparam int unsigned FIFO_AW     = 4;
    localparam int unsigned GAP_CYCLES  = 4;
    localparam int unsigned ACK_TIMEOUT = 16;
    localparam int SEL_BUSY  = 0;
    localparam int SEL_EN    = 1;
    localparam int SEL_DRAIN = 2;

    logic       clk      = 1'b0;
    logic       reset_n  = 1'b0;
    int         checks   = 0;
    int         errors   = 0;
    int         cyc      = 0;
    int         launches = 0;
    bit         model_en = 1'b1;
    bit         stall    = 1'b0;
    int         bit_clks = 10;
    logic [9:0] last_frame = '0;
    logic [7:0] exp_q[$];

    uart_tx_feeder_if #(.FIFO_AW(FIFO_AW)) bus ();

    uart_tx_feeder #(
        .FIFO_AW    (FIFO_AW),
        .GAP_CYCLES (GAP_CYCLES),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .uart_tx_clk(clk),
        .reset_n    (reset_n),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic probe(input int sel);
        case (sel)
            SEL_BUSY: return bus.tx_busy;
            SEL_EN:   return bus.tx_enable;
            default:  return bus.tx_idle && !bus.tx_busy && (exp_q.size() == 0);
        endcase
    endfunction

    task automatic wait_until(input string name, input int sel, input logic val, input int budget);
        int n = 0;
        while (probe(sel) !== val) begin
            if (n == budget) begin
                checks++;
                errors++;
                $display("FAIL %s: condition not reached within %0d cycles", name, budget);
                return;
            end
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wr(input logic [7:0] b, input bit expect_accept);
        bus.wr_data = b;
        bus.wr_en   = 1'b1;
        if (expect_accept) exp_q.push_back(b);
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_empty"},    bus.fifo_empty,  1);
        check({tag, "_full"},     bus.fifo_full,   0);
        check({tag, "_count"},    bus.fifo_count,  0);
        check({tag, "_idle"},     bus.tx_idle,     1);
        check({tag, "_enable"},   bus.tx_enable,   0);
        check({tag, "_data"},     bus.tx_data,     8'h00);
        check({tag, "_overflow"}, bus.overflow,    0);
        check({tag, "_timeout"},  bus.timeout_err, 0);
    endtask

    // Downstream bit-path: rising tx_enable starts a 10-bit frame of bit_clks clocks per bit.
    initial begin : bitpath
        logic       prev;
        logic [9:0] frame;
        prev        = 1'b0;
        bus.tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (model_en && bus.tx_enable && !prev) begin
                frame       = {1'b1, bus.tx_data, 1'b0};
                bus.tx_busy = 1'b1;
                repeat (10 * bit_clks) begin
                    @(posedge clk);
                    #2;
                end
                while (stall) begin
                    @(posedge clk);
                    #2;
                end
                last_frame  = frame;
                bus.tx_busy = 1'b0;
            end
            prev = bus.tx_enable;
        end
    end

    // Scoreboard monitor: every launch must present the oldest expected byte.
    initial begin : monitor
        logic       prev;
        logic [7:0] e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.tx_enable && !prev) begin
                launches++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_launch: tx_data %02h with no byte expected", bus.tx_data);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_data_order", bus.tx_data, e);
                end
            end
            prev = bus.tx_enable;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int fall_c;
        int rise_c;
        int hi;
        int lo;
        int n0;
        bus.wr_en     = 1'b0;
        bus.wr_data   = '0;
        bus.err_clear = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Single byte: launch latency and frame content
        wr(8'hA5, 1'b1);
        check("count_after_write", bus.fifo_count, 1);
        check("latency_n0", bus.tx_enable, 0);
        @(negedge clk);
        check("latency_n1", bus.tx_enable, 0);
        @(negedge clk);
        check("latency_n2", bus.tx_enable, 1);
        check("count_after_load", bus.fifo_count, 0);
        wait_until("single_drain", SEL_DRAIN, 1'b1, 300);
        check("frame_a5", last_frame, 10'b1101001010);
        check("idle_after_gap", bus.tx_idle, 1);

        // Burst into a stalled bit-path: fill, overflow, clear priority, drain
        stall = 1'b1;
        wr(8'hEE, 1'b1);
        wait_until("stall_busy", SEL_BUSY, 1'b1, 20);
        for (int i = 0; i < 16; i++) wr(8'(i), 1'b1);
        check("full_after_16", bus.fifo_full, 1);
        check("count_16", bus.fifo_count, 16);
        check("no_overflow_yet", bus.overflow, 0);
        wr(8'h10, 1'b0);
        check("overflow_set", bus.overflow, 1);
        check("count_still_16", bus.fifo_count, 16);
        bus.err_clear = 1'b1;
        wr(8'h11, 1'b0);
        bus.err_clear = 1'b0;
        check("clear_beats_set", bus.overflow, 0);
        stall = 1'b0;
        wait_until("burst_drain", SEL_DRAIN, 1'b1, 3000);
        check("burst_count_zero", bus.fifo_count, 0);
        check("burst_empty", bus.fifo_empty, 1);

        // Wrap: 40 bytes with writes interleaved against pops
        bit_clks = 2;
        wr(8'h03, 1'b1);
        check("pair_count_a", bus.fifo_count, 1);
        @(negedge clk);
        check("pair_count_b", bus.fifo_count, 1);
        wr(8'h0A, 1'b1);
        check("wr_pop_same_cycle", bus.fifo_count, 1);
        check("pair_launch", bus.tx_enable, 1);
        for (int i = 2; i < 40; i++) begin
            wr(8'(i * 7 + 3), 1'b1);
            repeat (19) @(negedge clk);
        end
        wait_until("wrap_drain", SEL_DRAIN, 1'b1, 2000);
        check("wrap_count_zero", bus.fifo_count, 0);

        // Gap timing: relaunch GAP_CYCLES+2 edges after busy is first sampled low
        bit_clks = 10;
        wr(8'h5A, 1'b1);
        wr(8'hC3, 1'b1);
        wait_until("gap_busy_hi", SEL_BUSY, 1'b1, 20);
        wait_until("gap_busy_lo", SEL_BUSY, 1'b0, 200);
        fall_c = cyc;
        wait_until("gap_relaunch", SEL_EN, 1'b1, 20);
        rise_c = cyc;
        check("gap_edges", rise_c - fall_c - 1, GAP_CYCLES + 2);
        wait_until("gap_drain", SEL_DRAIN, 1'b1, 300);

        // Timeout: no busy response at all
        model_en = 1'b0;
        wr(8'h3C, 1'b1);
        wr(8'h7E, 1'b1);
        wait_until("to_launch", SEL_EN, 1'b1, 10);
        hi = 0;
        while (bus.tx_enable && hi < 64) begin
            hi++;
            @(negedge clk);
        end
        check("to_enable_high", hi, ACK_TIMEOUT);
        check("to_err_set", bus.timeout_err, 1);
        lo = 0;
        while (!bus.tx_enable && lo < 64) begin
            lo++;
            @(negedge clk);
        end
        check("to_enable_low", lo, GAP_CYCLES + 2);
        wait_until("to_second_end", SEL_EN, 1'b0, 40);
        check("to_err_held", bus.timeout_err, 1);
        bus.err_clear = 1'b1;
        @(negedge clk);
        bus.err_clear = 1'b0;
        check("to_err_cleared", bus.timeout_err, 0);
        wait_until("to_drain", SEL_DRAIN, 1'b1, 40);
        model_en = 1'b1;

        // Reset during WAIT_DONE discards the queue and the frame in flight
        wr(8'h11, 1'b1);
        wr(8'h22, 1'b1);
        wr(8'h33, 1'b1);
        wait_until("rst_busy", SEL_BUSY, 1'b1, 20);
        repeat (3) @(negedge clk);
        exp_q.delete();
        n0 = launches;
        #1 reset_n = 1'b0;
        #1;
        check_reset_state("midframe_reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_reset_count", bus.fifo_count, 0);
        repeat (200) @(negedge clk);
        check("no_launch_after_reset", launches, n0);
        check("post_reset_idle", bus.tx_idle, 1);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
